// File: rtl/spectrum_ram_arbiter.sv
// spectrum_ram_arbiter
// Shares the single-port spectrum bar RAM between the display read path and
// the spectrum writer. The display owns the RAM during active video; writer
// updates are queued in a small FIFO and drained into the RAM during blanking.
module spectrum_ram_arbiter #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          video_on,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic [DATA_W-1:0]             rd_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic                          ram_we,
   output logic [DATA_W-1:0]             ram_wdata,
   input  logic [DATA_W-1:0]             ram_rdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          drain_busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [1:0] ST_BLANK_IDLE = 2'd0;
   localparam logic [1:0] ST_DISP       = 2'd1;
   localparam logic [1:0] ST_DRAIN      = 2'd2;

   localparam logic [LVL_W-1:0] C_FULL = LVL_W'(FIFO_DEPTH);

   // Write-buffer storage; contents need no reset, occupancy is tracked by r_count.
   logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_count;
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_ram_we;
   logic [DATA_W-1:0] r_ram_wdata;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [1:0]        w_state_next;

   assign w_full   = (r_count == C_FULL);
   assign w_empty  = (r_count == '0);
   // Ready comes from the registered count only, so a pop in the same cycle
   // never lets a push into a full buffer.
   assign wr_ready = !w_full;
   assign w_push   = wr_valid && !w_full;
   // A pop happens exactly when the head is registered onto the RAM write port.
   assign w_pop    = !video_on && !w_empty;

   // Next state: video always wins; otherwise drain whenever entries are pending.
   always_comb begin
      w_state_next = ST_BLANK_IDLE;
      if (video_on) begin
         w_state_next = ST_DISP;
      end else if (!w_empty) begin
         w_state_next = ST_DRAIN;
      end
   end

   // Store a pushed entry at the tail slot.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= wr_addr;
         r_fifo_data[r_wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // State register and registered RAM port, driven from the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_BLANK_IDLE;
         r_ram_addr  <= '0;
         r_ram_we    <= 1'b0;
         r_ram_wdata <= '0;
      end else begin
         r_state <= w_state_next;
         case (w_state_next)
            ST_DISP: begin
               r_ram_addr <= rd_addr;
               r_ram_we   <= 1'b0;
            end
            ST_DRAIN: begin
               r_ram_addr  <= r_fifo_addr[r_rd_ptr];
               r_ram_wdata <= r_fifo_data[r_rd_ptr];
               r_ram_we    <= 1'b1;
            end
            default: begin
               r_ram_we <= 1'b0;
            end
         endcase
      end
   end

   assign ram_addr   = r_ram_addr;
   assign ram_we     = r_ram_we;
   assign ram_wdata  = r_ram_wdata;
   assign fifo_level = r_count;
   assign drain_busy = (r_state == ST_DRAIN);
   // Read data is only meaningful to the display during active video.
   assign rd_data    = ram_rdata;

endmodule

// File: tb/tb_spectrum_ram_arbiter.sv
// Self-checking bench for spectrum_ram_arbiter with a behavioural 512x8 RAM.
module tb_spectrum_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       video_on = 1'b0;
   logic [8:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [8:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [8:0] ram_addr;
   logic       ram_we;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic [3:0] fifo_level;
   logic       drain_busy;

   logic       preload_req = 1'b1;
   logic [7:0] mem [512];
   logic [16:0] wlog [$];
   logic [16:0] exp_log [$];
   int          chk_ptr = 0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spectrum_ram_arbiter #(.FIFO_DEPTH(8), .ADDR_W(9), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .video_on(video_on), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .fifo_level(fifo_level), .drain_busy(drain_busy)
   );

   // Synchronous-read RAM model with write logging
   always @(posedge clk) begin
      if (preload_req) begin
         for (int i = 0; i < 512; i++) mem[i] <= 8'(i + 100);
      end else begin
         if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wlog.push_back({ram_addr, ram_wdata});
         end
         ram_rdata <= mem[ram_addr];
      end
   end

   typedef struct {
      logic       video_on;
      logic [8:0] rd_addr;
      logic       wr_valid;
      logic [8:0] wr_addr;
      logic [7:0] wr_data;
      logic [3:0] exp_level;
      logic       exp_ready;
      logic       exp_we;
      logic [8:0] exp_addr;
      logic [7:0] exp_wdata;
      logic       exp_busy;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_one(input logic [8:0] a, input logic [7:0] d, input bit log_it);
      bit acc;
      acc = 1'b0;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      for (int c = 0; c < 50 && !acc; c++) begin
         acc = wr_ready;
         step();
      end
      wr_valid = 1'b0;
      check("push_accept", int'(acc), 1);
      if (acc && log_it) exp_log.push_back({a, d});
      $display("push addr=%0d data=%02h level=%0d", a, d, fifo_level);
   endtask

   task automatic drain_all();
      bit done;
      done = 1'b0;
      video_on = 1'b0;
      wr_valid = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         if (fifo_level == 0) done = 1'b1;
         else step();
      end
      check("drain_timeout", int'(done), 1);
      step();
      step();
   endtask

   task automatic check_writes();
      check("write_count", wlog.size(), exp_log.size());
      for (int i = chk_ptr; i < exp_log.size() && i < wlog.size(); i++) begin
         check("write_order", int'(wlog[i]), int'(exp_log[i]));
      end
      chk_ptr = exp_log.size();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      bit acc;
      bit done;
      int base;

      // Push 5/6/7 during video, then drain in blanking
      tbl[0] = '{1'b1, 9'd3, 1'b1, 9'd5, 8'h11, 4'd1, 1'b1, 1'b0, 9'd3, 8'h00, 1'b0};
      tbl[1] = '{1'b1, 9'd4, 1'b1, 9'd6, 8'h22, 4'd2, 1'b1, 1'b0, 9'd4, 8'h00, 1'b0};
      tbl[2] = '{1'b1, 9'd5, 1'b1, 9'd7, 8'h33, 4'd3, 1'b1, 1'b0, 9'd5, 8'h00, 1'b0};
      tbl[3] = '{1'b0, 9'd0, 1'b0, 9'd0, 8'h00, 4'd2, 1'b1, 1'b1, 9'd5, 8'h11, 1'b1};
      tbl[4] = '{1'b0, 9'd0, 1'b0, 9'd0, 8'h00, 4'd1, 1'b1, 1'b1, 9'd6, 8'h22, 1'b1};
      tbl[5] = '{1'b0, 9'd0, 1'b0, 9'd0, 8'h00, 4'd0, 1'b1, 1'b1, 9'd7, 8'h33, 1'b1};
      tbl[6] = '{1'b0, 9'd0, 1'b0, 9'd0, 8'h00, 4'd0, 1'b1, 1'b0, 9'd7, 8'h00, 1'b0};

      // Reset
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_level", fifo_level, 0);
      check("rst_ready", wr_ready, 1);
      check("rst_we", ram_we, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_busy", drain_busy, 0);
      preload_req = 1'b0;
      rst = 1'b0;
      step();
      check("post_rst_ready", wr_ready, 1);

      // Display sweep 0..19
      base = wlog.size();
      video_on = 1'b1;
      for (int c = 0; c < 22; c++) begin
         if (c < 20) rd_addr = 9'(c);
         if (c >= 2) begin
            check("sweep_rd_data", rd_data, (c - 2) + 100);
            $display("sweep addr=%0d rd_data=%0d", c - 2, rd_data);
         end
         step();
      end
      check("sweep_no_write", wlog.size() - base, 0);
      video_on = 1'b0;
      step();

      // Table-driven push then drain
      for (int i = 0; i < 7; i++) begin
         video_on = tbl[i].video_on;
         rd_addr  = tbl[i].rd_addr;
         wr_valid = tbl[i].wr_valid;
         wr_addr  = tbl[i].wr_addr;
         wr_data  = tbl[i].wr_data;
         if (tbl[i].wr_valid) exp_log.push_back({tbl[i].wr_addr, tbl[i].wr_data});
         step();
         check("vec_level", fifo_level, tbl[i].exp_level);
         check("vec_ready", wr_ready, tbl[i].exp_ready);
         check("vec_we", ram_we, tbl[i].exp_we);
         check("vec_addr", ram_addr, tbl[i].exp_addr);
         check("vec_busy", drain_busy, tbl[i].exp_busy);
         if (tbl[i].exp_we) check("vec_wdata", ram_wdata, tbl[i].exp_wdata);
         $display("vec %0d level=%0d we=%0d addr=%0d wdata=%02h busy=%0d",
                  i, fifo_level, ram_we, ram_addr, ram_wdata, drain_busy);
      end
      wr_valid = 1'b0;
      check("mem5", mem[5], 8'h11);
      check("mem6", mem[6], 8'h22);
      check("mem7", mem[7], 8'h33);
      check_writes();

      // Overflow: 10 pushes into an 8-deep buffer during video
      video_on = 1'b1;
      p = 0;
      for (int c = 0; c < 20 && p < 8; c++) begin
         wr_valid = 1'b1;
         wr_addr  = 9'(20 + p);
         wr_data  = 8'(8'h40 + p);
         acc = wr_ready;
         step();
         if (acc) begin
            exp_log.push_back({wr_addr, wr_data});
            p++;
         end
      end
      check("ovf_accepted8", p, 8);
      check("ovf_level_full", fifo_level, 8);
      check("ovf_ready_low", wr_ready, 0);
      base = wlog.size();
      wr_addr = 9'd28;
      wr_data = 8'h48;
      repeat (3) step();
      check("ovf_level_hold", fifo_level, 8);
      check("ovf_ready_hold", wr_ready, 0);
      check("ovf_no_write", wlog.size() - base, 0);
      video_on = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (p < 10) begin
            wr_valid = 1'b1;
            wr_addr  = 9'(20 + p);
            wr_data  = 8'(8'h40 + p);
         end else begin
            wr_valid = 1'b0;
         end
         acc = wr_valid && wr_ready;
         step();
         if (acc) begin
            exp_log.push_back({wr_addr, wr_data});
            p++;
         end
         if (p == 10 && fifo_level == 0) done = 1'b1;
      end
      wr_valid = 1'b0;
      check("ovf_done", int'(done), 1);
      step();
      step();
      check("ovf_pushed10", p, 10);
      check_writes();
      $display("overflow scenario writes=%0d", wlog.size());

      // Partial drain interrupted by video
      video_on = 1'b1;
      for (int k = 0; k < 6; k++) push_one(9'(40 + k), 8'(8'h80 + k), 1'b1);
      check("pd_level6", fifo_level, 6);
      base = wlog.size();
      video_on = 1'b0;
      step();
      step();
      check("pd_level4", fifo_level, 4);
      video_on = 1'b1;
      rd_addr  = 9'd41;
      step();
      check("pd_we_off", ram_we, 0);
      check("pd_busy_off", drain_busy, 0);
      rd_addr = 9'd45;
      step();
      check("pd_rd41", rd_data, 8'h81);
      rd_addr = 9'd40;
      step();
      check("pd_rd45", rd_data, 145);
      step();
      check("pd_rd40", rd_data, 8'h80);
      check("pd_two_writes", wlog.size() - base, 2);
      check("pd_level_disp", fifo_level, 4);
      drain_all();
      check_writes();
      check("pd_mem45", mem[45], 8'h85);

      // Same-address ordering plus simultaneous push/pop at level 7
      video_on = 1'b1;
      push_one(9'd9, 8'hA0, 1'b1);
      for (int k = 0; k < 5; k++) push_one(9'(60 + k), 8'(8'h60 + k), 1'b1);
      push_one(9'd9, 8'hB0, 1'b1);
      check("sa_level7", fifo_level, 7);
      video_on = 1'b0;
      wr_valid = 1'b1;
      wr_addr  = 9'd70;
      wr_data  = 8'hC0;
      check("sa_ready", wr_ready, 1);
      step();
      exp_log.push_back({9'd70, 8'hC0});
      wr_valid = 1'b0;
      check("sa_level_const", fifo_level, 7);
      check("sa_first_we", ram_we, 1);
      check("sa_first_addr", ram_addr, 9);
      check("sa_first_data", ram_wdata, 8'hA0);
      drain_all();
      check_writes();
      check("sa_mem9", mem[9], 8'hB0);
      check("sa_mem70", mem[70], 8'hC0);

      // Reset in the middle of a drain
      video_on = 1'b1;
      for (int k = 0; k < 5; k++) push_one(9'(80 + k), 8'(8'hD0 + k), 1'b0);
      video_on = 1'b0;
      step();
      check("mr_we_draining", ram_we, 1);
      check("mr_level4", fifo_level, 4);
      base = wlog.size();
      rst = 1'b1;
      #1;
      check("mr_we_drop", ram_we, 0);
      check("mr_level0", fifo_level, 0);
      check("mr_busy0", drain_busy, 0);
      check("mr_ready", wr_ready, 1);
      @(negedge clk);
      step();
      rst = 1'b0;
      repeat (10) step();
      check("mr_no_writes", wlog.size() - base, 0);
      check("mr_level_after", fifo_level, 0);
      check("mr_mem80", mem[80], 8'hB4);
      $display("mid-drain reset writes after rst=%0d", wlog.size() - base);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spectrum_ram_arbiter.md
Name: spectrum_ram_arbiter

Overview:
- Shares the single-port 512x8 spectrum bar RAM between two users:
  - the display read path, which issues one bar address per pixel clock while video is active;
  - the spectrum writer, which delivers new bar magnitudes through a valid/ready handshake.
- The display owns the RAM during active video.
- Writes are buffered in a small FIFO and drained into the RAM only during blanking, so the display never sees a port conflict.
- Sits between the bar-drawing pixel generator, the spectrum/FFT result stage and the RAM macro.

Parameters:
- FIFO_DEPTH, 8, write-buffer entries; power of two, 2..64.
- ADDR_W, 9, RAM address width (512 bars).
- DATA_W, 8, bar magnitude width.

Ports:
- clk  in  1  pixel clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- video_on  in  1  active-video flag from the sync generator.
- rd_addr  in  ADDR_W  display bar address, registered by the pixel generator.
- rd_data  out  DATA_W  bar magnitude returned to the display.
- wr_valid  in  1  writer has an entry.
- wr_ready  out  1  FIFO can accept an entry.
- wr_addr  in  ADDR_W  bar index to update.
- wr_data  in  DATA_W  new magnitude.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_rdata  in  DATA_W  RAM read data; synchronous read, 1-cycle latency.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- drain_busy  out  1  high while in DRAIN.

Behaviour:
- Reset (async, immediate):
  - state=BLANK_IDLE, FIFO emptied, fifo_level=0.
  - ram_we=0, ram_addr=0, ram_wdata=0, drain_busy=0.
  - wr_ready=1 as soon as rst deasserts.
  - Reset mid-drain discards all pending entries; no partial write is issued after rst asserts.
- Write side:
  - wr_ready = (fifo_level != FIFO_DEPTH), combinational from registered count.
  - Push on clk edge when wr_valid & wr_ready.
  - wr_addr/wr_data must be held while wr_valid & !wr_ready; the writer must not drop requests.
  - Pushes are accepted in every state, including during reset release.
- State machine, next state from video_on and FIFO status sampled at each edge:
  - DISP: entered whenever video_on=1, from any state.
    - ram_addr<=rd_addr, ram_we<=0.
    - Any drain in progress is suspended; no entry is popped.
  - BLANK_IDLE: video_on=0 and FIFO empty.
    - ram_we<=0, ram_addr holds its last value.
  - DRAIN: video_on=0 and FIFO non-empty.
    - Each cycle: ram_addr<=head.addr, ram_wdata<=head.data, ram_we<=1, pop head.
    - Returns to BLANK_IDLE after the cycle that pops the last entry.
    - Goes to DISP if video_on=1.
  - An entry is popped only in a cycle where ram_we is registered high for it, so entries are never lost or duplicated.
- Simultaneous push and pop: both occur and the level is unchanged. A push when full is refused even if a pop happens the same cycle, because ready is computed from the current count.
- Ordering:
  - Entries are written in FIFO order.
  - Two entries to the same address: the later one wins in RAM.
- Read latency: rd_addr sampled at edge N produces ram_addr at N+1 and ram_rdata (= rd_data) at N+2.
  - rd_data = ram_rdata, combinational pass-through.
  - Outside DISP, rd_data is don't-care; the display ignores it while video_on=0.
- video_on falling: the first DRAIN write is registered on the first edge where video_on=0 is sampled. The display's in-flight read from the last active pixel still returns correctly because the RAM read completes in that same cycle.
- Address arithmetic: plain ADDR_W-bit, no range check; all 512 indices are valid. FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset → fifo_level=0, wr_ready=1, ram_we=0, ram_addr=0; assert rst mid-DRAIN with 5 entries queued → ram_we drops immediately, level=0, no further writes.
- video_on=1 for 20 cycles, rd_addr sweeping 0..19; RAM preloaded with mem[i]=i+100 → rd_data at edge N+2 equals rd_addr(N)+100 for every cycle; ram_we never high.
- video_on=1, push 3 entries (addr 5/6/7, data 0x11/0x22/0x33) → fifo_level=3, ram_we=0; video_on→0 → three consecutive ram_we pulses in order, then BLANK_IDLE, level=0, mem[5..7] correct.
- Push 10 entries back-to-back with FIFO_DEPTH=8 during video → wr_ready low after the 8th acceptance, entries 9–10 held; after blanking begins, all 10 land in RAM in order with none lost.
- Drain of 6 entries, video_on rises after 2 writes → exactly 2 RAM writes, level=4, DISP reads correct; at next blanking the remaining 4 are written.
- Same-address entries (addr 9: 0xA0 then 0xB0) plus concurrent push/pop at level=FIFO_DEPTH-1 → mem[9]=0xB0; level constant during the simultaneous push/pop cycle.
